// File: rtl/alu_controller_if.sv
// Request bus from decode into alu_controller.
// A request transfers on a rising clk edge where req_valid && req_ready; the payload must be stable while req_valid is high, and valid may drop without a transfer.
interface alu_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_select;
  logic [7:0] req_data1;
  logic [7:0] req_data2;
  logic [2:0] req_dest;
  logic       req_fwd1;

  modport master (
    output req_valid, req_select, req_data1, req_data2, req_dest, req_fwd1,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_select, req_data1, req_data2, req_dest, req_fwd1,
    output req_ready
  );
endinterface

// File: rtl/alu_controller.sv
// Sequencer that latches one ALU op per handshake, holds operands for the settle time, then retires it as a writeback or branch pulse.
// Optional macro ALU_CTRL_FWD_EN: REQ_FWD1 substitutes the last written result for operand 1.
module alu_controller #(
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_controller_if.slave  req,
  output logic [7:0]       alu_data1,
  output logic [7:0]       alu_data2,
  output logic [2:0]       alu_select,
  input  logic [7:0]       alu_result,
  output logic             wb_en,
  output logic [2:0]       wb_addr,
  output logic [7:0]       wb_data,
  output logic             br_taken,
  output logic             err,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ADD_LOAD   = 4'(ADD_WAIT - 1);
  localparam logic [3:0] LOGIC_LOAD = 4'(LOGIC_WAIT - 1);
  localparam logic [2:0] SEL_ADD    = 3'b001;
  localparam logic [2:0] SEL_BEQ    = 3'b100;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] alu_data1_q, alu_data1_d;
  logic [7:0] alu_data2_q, alu_data2_d;
  logic [2:0] alu_select_q, alu_select_d;
  logic [2:0] dest_q, dest_d;
  logic       wb_en_q, wb_en_d;
  logic [2:0] wb_addr_q, wb_addr_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       br_taken_q, br_taken_d;
  logic       err_q, err_d;
  logic       ready;
  logic [7:0] op1;

`ifdef ALU_CTRL_FWD_EN
  logic [7:0] last_result_q, last_result_d;
  assign op1 = req.req_fwd1 ? last_result_q : req.req_data1;
`else
  logic unused_fwd1;
  assign unused_fwd1 = req.req_fwd1;
  assign op1         = req.req_data1;
`endif

  assign ready = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    dest_d       = dest_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    br_taken_d   = 1'b0;
    err_d        = 1'b0;
`ifdef ALU_CTRL_FWD_EN
    last_result_d = last_result_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          // Illegal selects are rejected in place: the ALU keeps its previous op.
          if (req.req_select > SEL_BEQ) begin
            err_d = 1'b1;
          end else begin
            alu_data1_d  = op1;
            alu_data2_d  = req.req_data2;
            alu_select_d = req.req_select;
            dest_d       = req.req_dest;
            cnt_d        = (req.req_select == SEL_ADD) ? ADD_LOAD : LOGIC_LOAD;
            state_d      = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (alu_select_q == SEL_BEQ) begin
            br_taken_d = alu_result[0];
          end else begin
            wb_en_d   = 1'b1;
            wb_addr_d = dest_q;
            wb_data_d = alu_result;
`ifdef ALU_CTRL_FWD_EN
            last_result_d = alu_result;
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      alu_data1_q  <= 8'd0;
      alu_data2_q  <= 8'd0;
      alu_select_q <= 3'd0;
      dest_q       <= 3'd0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= 3'd0;
      wb_data_q    <= 8'd0;
      br_taken_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef ALU_CTRL_FWD_EN
      last_result_q <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      dest_q       <= dest_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      br_taken_q   <= br_taken_d;
      err_q        <= err_d;
`ifdef ALU_CTRL_FWD_EN
      last_result_q <= last_result_d;
`endif
    end
  end

  assign req.req_ready = ready;
  assign busy          = ~ready;
  assign alu_data1     = alu_data1_q;
  assign alu_data2     = alu_data2_q;
  assign alu_select    = alu_select_q;
  assign wb_en         = wb_en_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign br_taken      = br_taken_q;
  assign err           = err_q;
  assign dbg_state     = state_q;
endmodule

// File: doc/alu_controller.md
# alu_controller

Sequencer that owns the 8-bit `alu` datapath and drives it on behalf of the instruction stage. It accepts one operation per valid/ready handshake, holds the ALU operands and SELECT stable for the op's settle time, then captures the ALU output. It retires the op either as a one-cycle register-file writeback or, for BEQ, as a one-cycle branch-taken pulse. It sits between decode and the register file and replaces direct combinational use of the ALU.

## Interface
- ADD_WAIT, 2: cycles ALU inputs are held before capture for SELECT 3'b001 (ADD); legal range 1–15.
- LOGIC_WAIT, 1: hold cycles for SELECT 3'b000/010/011/100 (FWD/AND/OR/BEQ); legal range 1–15.
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_SELECT  in  3  ALU operation code.
- REQ_DATA1  in  8  operand 1.
- REQ_DATA2  in  8  operand 2.
- REQ_DEST  in  3  destination register address.
- REQ_FWD1  in  1  use last written result as operand 1; active only with ALU_CTRL_FWD_EN.
- ALU_DATA1  out  8  registered ALU operand 1.
- ALU_DATA2  out  8  registered ALU operand 2.
- ALU_SELECT  out  3  registered ALU SELECT.
- ALU_RESULT  in  8  ALU RESULT.
- WB_EN  out  1  one-cycle register write strobe.
- WB_ADDR  out  3  write address.
- WB_DATA  out  8  write data.
- BR_TAKEN  out  1  one-cycle pulse when a BEQ compares equal.
- ERR  out  1  one-cycle pulse for an illegal SELECT (3'b101–3'b111).
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE
  - REQ_READY=1.
  - Handshake fires on the edge where REQ_VALID&REQ_READY.
  - On handshake: latch SELECT, DEST, DATA1 and DATA2 into ALU_* and the dest register.
  - Load the wait counter with (wait−1), where wait is ADD_WAIT for 3'b001 and LOGIC_WAIT otherwise.
  - Go to EXEC.
- Illegal SELECT at handshake: ERR=1 next cycle, state stays IDLE, no WB_EN, no BR_TAKEN, ALU_* unchanged.
- EXEC
  - ALU_* held constant; REQ_READY=0.
  - If counter≠0, decrement.
  - If counter=0, capture and go to DONE.
- Capture
  - SELECT 3'b100: BR_TAKEN ← (ALU_RESULT[0]==1); WB_EN ← 0.
  - Else: WB_EN ← 1, WB_DATA ← ALU_RESULT, WB_ADDR ← dest, last_result ← ALU_RESULT.
- DONE: REQ_READY=0; WB_EN/BR_TAKEN are high this cycle only; next edge → IDLE.
- Strobes: WB_EN, BR_TAKEN and ERR are never high for more than one cycle, and never together.
- WB_DATA and WB_ADDR hold their last values between strobes.
- Widths: the counter is 4 bits; no arithmetic is performed here; operands pass through unmodified (except FWD substitution).

## Timing
- Reset
  - State=IDLE.
  - REQ_READY=1 from the first cycle after reset.
  - ALU_DATA1=ALU_DATA2=0, ALU_SELECT=3'b000.
  - WB_EN=BR_TAKEN=ERR=BUSY=0, WB_ADDR=0, WB_DATA=0, last_result=0.
- Latency: handshake at edge 0 → capture at edge W (W = wait) → WB_EN/BR_TAKEN high between edges W and W+1.
- Throughput: REQ_READY high again after edge W+1, so the next handshake is at the earliest at edge W+2. The period is W+2 cycles per op.
- Defaults: ADD takes 4 cycles per op; FWD/AND/OR/BEQ take 3.
- BUSY = ~REQ_READY.
- REQ_VALID may drop without accept; requests are not queued; inputs are ignored outside IDLE.
- RESET mid-EXEC or mid-DONE
  - Abort; no strobe issued for the aborted op.
  - All outputs go to reset values on that edge.
  - RESET has priority over a simultaneous handshake.

## Configuration
- ALU_CTRL_FWD_EN defined
  - At handshake with REQ_FWD1=1, ALU_DATA1 ← last_result instead of REQ_DATA1.
  - last_result is updated only on WB_EN captures; BEQ, ERR and aborted ops do not update it.
  - Reset value of last_result is 0.
- Undefined: REQ_FWD1 is ignored, last_result is not implemented, and ALU_DATA1 always ← REQ_DATA1.

## Test plan
- ADD, default params
  - Stimulus: RESET then RESET=0; handshake SELECT=001, DATA1=8'h05, DATA2=8'h03, DEST=3; ALU model returns sum.
  - Response: WB_EN high exactly one cycle, 2 edges after the handshake edge, WB_ADDR=3, WB_DATA=8'h08; REQ_READY low for 3 cycles.
- BEQ
  - Equal case: SELECT=100, DATA1=DATA2=8'h2A → BR_TAKEN pulses once, WB_EN stays 0.
  - Unequal case: repeat with DATA2=8'h2B → no BR_TAKEN.
- Back-to-back AND then OR with REQ_VALID held high: the second handshake occurs exactly 3 cycles after the first; WB_DATA values are 8'h0C&8'h0A=8'h08, then 8'h0C|8'h0A=8'h0E.
- Illegal SELECT=110: ERR pulses one cycle, no WB_EN, REQ_READY stays 1, ALU_* unchanged.
- Reset mid-operation
  - Stimulus: assert RESET for one cycle in EXEC of an ADD.
  - Response: no WB_EN ever issued for that op; all outputs are at reset values the cycle after; a new op then completes normally.
- With ALU_CTRL_FWD_EN
  - Stimulus: FWD 8'h11 to DEST=1, then ADD with REQ_FWD1=1, REQ_DATA1=8'hFF, DATA2=8'h01.
  - Response: ALU_DATA1=8'h11, WB_DATA=8'h12.
  - Without the macro, the same ADD yields ALU_DATA1=8'hFF.
